instr_encoder: RTL
==================

// Module: instr_encoder
// PURPOSE
//  Packs RISC-V RV32I instruction fields (opcode/rd/rs1/rs2/funct3/funct7/imm) into 32-bit words.
//  Performs the immediate bit-scatter for I/S/B/U/J formats.
//  Buffers results in a small FIFO and emits them with a running word address.
//  Drives the instruction-memory write port of the test loader and the self-check harness.
// PARAMETERS
//  DEPTH      2   output FIFO entries (>=1)
//  ADDR_W     10  width of out_addr (word address)
//  BASE_ADDR  0   out_addr value after reset
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-high
//  in_valid    in   1       field bundle valid
//  in_ready    out  1       encoder can accept a bundle
//  in_opcode   in   7       opcode
//  in_rd       in   5       destination register
//  in_funct3   in   3       funct3
//  in_rs1      in   5       source register 1
//  in_rs2      in   5       source register 2
//  in_funct7   in   7       funct7 (R-type only)
//  in_imm      in   32      immediate, two's complement, byte offset for B/J
//  out_valid   out  1       out_instr/out_addr/out_err valid
//  out_ready   in   1       consumer accepts word
//  out_instr   out  32      encoded instruction
//  out_addr    out  ADDR_W  word address of out_instr
//  out_err     out  1       encoding error for this word
// BEHAVIOUR
//  Reset (async, any cycle): FIFO flushed; out_valid=0; out_instr=0; out_err=0; out_addr=BASE_ADDR; in_ready=1 once reset deasserts.
//  Handshake: a transfer occurs on an edge where valid&&ready. No combinational in->out path.
//  Latency: bundle accepted at edge N -> out_valid=1 after edge N (one cycle), provided the FIFO was empty.
//  in_ready = (count < DEPTH). A pop in the same cycle does NOT raise in_ready; full blocks push even during a pop.
//  Simultaneous push+pop when not full: both occur, count unchanged. Output order is strictly FIFO.
//  out_addr advances +1 on each output handshake. Wraps modulo 2^ADDR_W with no flag.
//  Encoding, by opcode:
//   R   0110011: {f7,rs2,rs1,f3,rd,op}
//   I   0000011/0010011/1100111: {imm[11:0],rs1,f3,rd,op}
//   S   0100011: {imm[11:5],rs2,rs1,f3,imm[4:0],op}
//   B   1100011: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
//   U   0110111/0010111: {imm[31:12],rd,op}
//   J   1101111: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
//   Unused field bits are ignored.
//  Unknown opcode: out_instr=32'h00000013 (NOP); out_err=1.
//  out_err is stored per entry and travels with its word.
// CONFIGURATION
//  IMM_RANGE_CHECK_EN defined:
//   out_err=1 also when the immediate is not representable; the word is still encoded, truncated.
//   I/S: imm is not sign-extended from 12 bits.
//   B: imm[0]!=0, or imm is not sign-extended from 13 bits.
//   J: imm[0]!=0, or imm is not sign-extended from 21 bits.
//   U: imm[11:0]!=0.
//  IMM_RANGE_CHECK_EN undefined: no range check; out_err only flags an unknown opcode; high/low bits are silently dropped.
// TESTING
//  addi op=0010011 rd=1 f3=0 rs1=0 imm=5 -> out_instr=0x00500093, out_addr=0, out_err=0, one cycle after accept.
//  sw op=0100011 f3=2 rs1=1 rs2=2 imm=8, then beq op=1100011 rs1=rs2=0 imm=-4 -> 0x0020A423 @addr0, 0xFE000EE3 @addr1.
//  jal op=1101111 rd=1 imm=0x800 -> 0x001000EF. op=7'h7F -> 0x00000013 with out_err=1.
//  out_ready=0, push 3 bundles -> in_ready=0 after 2 (DEPTH=2); release -> words in order at addr 0,1,2; full+pop cycle accepts nothing.
//  addi rd=1 imm=4096 -> 0x00000093; out_err=1 with IMM_RANGE_CHECK_EN, 0 without.
//  reset asserted while FIFO holds 2 words -> out_valid=0 immediately; next word appears at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder
//   Packs RV32I instruction fields into 32-bit words (R/I/S/B/U/J formats),
//   queues them in a DEPTH-entry FIFO and emits each word with a running
//   word address. Unknown opcodes produce a NOP with out_err set.
//
//   Optional feature macro: IMM_RANGE_CHECK_EN
//     When defined, out_err is also raised when the immediate cannot be
//     represented in the selected format; the word is still encoded with the
//     truncated immediate.
//
// Ports
//   clk, reset              clock (rising edge), async active-high reset
//   in_valid / in_ready     field bundle handshake
//   in_opcode .. in_imm     instruction fields (imm is two's complement)
//   out_valid / out_ready   encoded word handshake
//   out_instr, out_addr     encoded word and its word address
//   out_err                 encoding error flag travelling with the word
module instr_encoder #(
  parameter int                DEPTH     = 2,
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUIP = 7'b0010111;
  localparam logic [6:0] OP_J    = 7'b1101111;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } entry_t;

  // ---------------------------------------------------------------------
  // Field packing
  // ---------------------------------------------------------------------
  entry_t enc;

`ifdef IMM_RANGE_CHECK_EN
  // An immediate fits N bits when every bit from N-1 upward matches.
  logic fit12, fit13, fit21;
  assign fit12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fit13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fit21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);
`endif

  always_comb begin
    enc.instr = NOP;
    enc.err   = 1'b1;
    case (in_opcode)
      OP_R: begin
        enc.instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        enc.err   = 1'b0;
      end
      OP_LOAD, OP_IMM, OP_JALR: begin
        enc.instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
`ifdef IMM_RANGE_CHECK_EN
        enc.err   = ~fit12;
`else
        enc.err   = 1'b0;
`endif
      end
      OP_S: begin
        enc.instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
`ifdef IMM_RANGE_CHECK_EN
        enc.err   = ~fit12;
`else
        enc.err   = 1'b0;
`endif
      end
      OP_B: begin
        enc.instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
`ifdef IMM_RANGE_CHECK_EN
        enc.err   = in_imm[0] | ~fit13;
`else
        enc.err   = 1'b0;
`endif
      end
      OP_LUI, OP_AUIP: begin
        enc.instr = {in_imm[31:12], in_rd, in_opcode};
`ifdef IMM_RANGE_CHECK_EN
        enc.err   = |in_imm[11:0];
`else
        enc.err   = 1'b0;
`endif
      end
      OP_J: begin
        enc.instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
`ifdef IMM_RANGE_CHECK_EN
        enc.err   = in_imm[0] | ~fit21;
`else
        enc.err   = 1'b0;
`endif
      end
      default: begin
        enc.instr = NOP;
        enc.err   = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------
  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]  addr_q;
  logic               push, pop;

  // in_ready looks only at the registered count, so a pop never frees a
  // slot for a push in the same cycle.
  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= BASE_ADDR;
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= enc;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
        addr_q   <= addr_q + 1'b1;  // wraps silently
      end
    end
  end

  assign out_instr = mem_q[rd_ptr_q].instr;
  assign out_err   = mem_q[rd_ptr_q].err;
  assign out_addr  = addr_q;

endmodule
